// File: rtl/ccm_pkg.sv
// ccm_pkg: shared CCM widths, default aging limit and requester port IDs.
package ccm_pkg;
  localparam int CCM_ADDR_WIDTH = 11;
  localparam int CCM_DATA_WIDTH = 32;
  localparam int CCM_MAX_WAIT   = 7;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_id_e;
endpackage

// File: rtl/ccm_arb_2to1.sv
// ccm_arb_2to1: two-requester arbiter, A-priority with B aging, or round-robin when
// CCM_ARB_RR_EN is defined.
module ccm_arb_2to1
  import ccm_pkg::*;
#(
  parameter int MAX_WAIT = CCM_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
`ifdef CCM_ARB_RR_EN
  port_id_e last;
  // On contention the port that did not win last time takes the grant.
  assign gnt_b = rst_n & req_b & (!req_a | (last == PORT_A));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= PORT_A;
    else if (gnt_a | gnt_b) last <= gnt_b ? PORT_B : PORT_A;
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  logic          starved;
  assign starved = wait_cnt == CW'(MAX_WAIT);
  assign gnt_b   = rst_n & req_b & (!req_a | starved);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (req_b & !gnt_b) ? (starved ? wait_cnt : wait_cnt + 1'b1) : '0;
`endif
  assign gnt_a = rst_n & req_a & !gnt_b;
endmodule

// File: rtl/ccm_arbiter.sv
// ccm_arbiter: shares one CCM controller between port A and port B; read and write ports
// arbitrated independently, read data routed back to its owner (CCM_ARB_RR_EN selects round-robin).
module ccm_arbiter
  import ccm_pkg::*;
#(
  parameter int ADDR_WIDTH = CCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = CCM_DATA_WIDTH,
  parameter int MAX_WAIT   = CCM_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_rd,
  input  logic [ADDR_WIDTH-1:0] a_raddr,
  output logic                  a_rd_gnt,
  output logic                  a_rd_valid,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_waddr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_wr_gnt,
  input  logic                  b_rd,
  input  logic [ADDR_WIDTH-1:0] b_raddr,
  output logic                  b_rd_gnt,
  output logic                  b_rd_valid,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_waddr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_wr_gnt,
  output logic                  cntlr_rd,
  output logic [ADDR_WIDTH-1:0] cntlr_raddr,
  input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
  input  logic                  cntlr_rd_valid,
  output logic                  cntlr_wr,
  output logic [ADDR_WIDTH-1:0] cntlr_waddr,
  output logic [DATA_WIDTH-1:0] cntlr_wr_data
);
  port_id_e rd_owner;
  logic     rd_pend;
  ccm_arb_2to1 #(.MAX_WAIT(MAX_WAIT)) u_rd_arb (
    .clk(clk), .rst_n(rst_n), .req_a(a_rd), .req_b(b_rd), .gnt_a(a_rd_gnt), .gnt_b(b_rd_gnt)
  );
  ccm_arb_2to1 #(.MAX_WAIT(MAX_WAIT)) u_wr_arb (
    .clk(clk), .rst_n(rst_n), .req_a(a_wr), .req_b(b_wr), .gnt_a(a_wr_gnt), .gnt_b(b_wr_gnt)
  );
  always_comb begin
    cntlr_rd      = a_rd_gnt | b_rd_gnt;
    cntlr_raddr   = a_rd_gnt ? a_raddr : b_rd_gnt ? b_raddr : '0;
    cntlr_wr      = a_wr_gnt | b_wr_gnt;
    cntlr_waddr   = a_wr_gnt ? a_waddr : b_wr_gnt ? b_waddr : '0;
    cntlr_wr_data = a_wr_gnt ? a_wdata : b_wr_gnt ? b_wdata : '0;
    a_rd_valid    = cntlr_rd_valid & rd_pend & (rd_owner == PORT_A);
    b_rd_valid    = cntlr_rd_valid & rd_pend & (rd_owner == PORT_B);
    a_rd_data     = a_rd_valid ? cntlr_rd_data : '0;
    b_rd_data     = b_rd_valid ? cntlr_rd_data : '0;
  end
  // rd_pend drops any read in flight across a reset so stale controller data is never routed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_owner <= PORT_A;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= cntlr_rd;
      if (cntlr_rd) rd_owner <= b_rd_gnt ? PORT_B : PORT_A;
    end
endmodule
